// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - RV32I decode stage with registered ALU/control outputs
module alu_decode_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_Instr,
  input  logic        i_Valid,
  input  logic        i_Stall,
  input  logic        i_Flush,
  output logic [3:0]  o_AluCtrl,
  output logic        o_Op1Sel,
  output logic        o_Op2Sel,
  output logic [31:0] o_Imm,
  output logic [4:0]  o_Rs1,
  output logic [4:0]  o_Rs2,
  output logic [4:0]  o_Rd,
  output logic [2:0]  o_Funct3,
  output logic        o_RegWrite,
  output logic        o_MemRead,
  output logic        o_MemWrite,
  output logic        o_Branch,
  output logic        o_Jump,
  output logic        o_Illegal,
  output logic        o_Valid
);

  // ALU operation codes shared with the execute stage
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_BUF  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        f7_zero;
  logic        f7_alt;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opcode  = i_Instr[6:0];
  assign funct3  = i_Instr[14:12];
  assign funct7  = i_Instr[31:25];
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  assign imm_i = {{20{i_Instr[31]}}, i_Instr[31:20]};
  assign imm_s = {{20{i_Instr[31]}}, i_Instr[31:25], i_Instr[11:7]};
  assign imm_b = {{19{i_Instr[31]}}, i_Instr[31], i_Instr[7], i_Instr[30:25], i_Instr[11:8], 1'b0};
  assign imm_u = {i_Instr[31:12], 12'b0};
  assign imm_j = {{11{i_Instr[31]}}, i_Instr[31], i_Instr[19:12], i_Instr[20], i_Instr[30:21], 1'b0};

  logic [3:0]  d_alu;
  logic        d_op1;
  logic        d_op2;
  logic [31:0] d_imm;
  logic        d_rw;
  logic        d_mr;
  logic        d_mw;
  logic        d_br;
  logic        d_jp;
  logic        d_ill;

  // Combinational decode of the incoming instruction word
  always_comb begin
    d_alu = ALU_ADD;
    d_op1 = 1'b0;
    d_op2 = 1'b0;
    d_imm = 32'd0;
    d_rw  = 1'b0;
    d_mr  = 1'b0;
    d_mw  = 1'b0;
    d_br  = 1'b0;
    d_jp  = 1'b0;
    d_ill = 1'b0;
    case (opcode)
      OPC_OP: begin
        d_rw = 1'b1;
        case (funct3)
          3'b000: begin
            if (f7_zero)     d_alu = ALU_ADD;
            else if (f7_alt) d_alu = ALU_SUB;
            else             d_ill = 1'b1;
          end
          3'b101: begin
            if (f7_zero)     d_alu = ALU_SRL;
            else if (f7_alt) d_alu = ALU_SRA;
            else             d_ill = 1'b1;
          end
          3'b001: begin d_alu = ALU_SLL;  d_ill = !f7_zero; end
          3'b010: begin d_alu = ALU_SLT;  d_ill = !f7_zero; end
          3'b011: begin d_alu = ALU_SLTU; d_ill = !f7_zero; end
          3'b100: begin d_alu = ALU_XOR;  d_ill = !f7_zero; end
          3'b110: begin d_alu = ALU_OR;   d_ill = !f7_zero; end
          default: begin d_alu = ALU_AND; d_ill = !f7_zero; end
        endcase
      end
      OPC_OPIMM: begin
        d_op2 = 1'b1;
        d_imm = imm_i;
        d_rw  = 1'b1;
        case (funct3)
          3'b000: d_alu = ALU_ADD;
          3'b001: begin d_alu = ALU_SLL; d_ill = !f7_zero; end
          3'b010: d_alu = ALU_SLT;
          3'b011: d_alu = ALU_SLTU;
          3'b100: d_alu = ALU_XOR;
          3'b101: begin
            if (f7_zero)     d_alu = ALU_SRL;
            else if (f7_alt) d_alu = ALU_SRA;
            else             d_ill = 1'b1;
          end
          3'b110: d_alu = ALU_OR;
          default: d_alu = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        d_alu = ALU_BUF;
        d_op2 = 1'b1;
        d_imm = imm_u;
        d_rw  = 1'b1;
      end
      OPC_AUIPC: begin
        d_op1 = 1'b1;
        d_op2 = 1'b1;
        d_imm = imm_u;
        d_rw  = 1'b1;
      end
      OPC_LOAD: begin
        d_op2 = 1'b1;
        d_imm = imm_i;
        d_mr  = 1'b1;
        d_rw  = 1'b1;
      end
      OPC_STORE: begin
        d_op2 = 1'b1;
        d_imm = imm_s;
        d_mw  = 1'b1;
      end
      OPC_BRANCH: begin
        d_alu = ALU_SUB;
        d_imm = imm_b;
        d_br  = 1'b1;
      end
      OPC_JAL: begin
        d_op1 = 1'b1;
        d_op2 = 1'b1;
        d_imm = imm_j;
        d_jp  = 1'b1;
        d_rw  = 1'b1;
      end
      OPC_JALR: begin
        d_op2 = 1'b1;
        d_imm = imm_i;
        d_jp  = 1'b1;
        d_rw  = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    // An illegal encoding must never produce side effects downstream
    if (d_ill) begin
      d_alu = ALU_ADD;
      d_op1 = 1'b0;
      d_op2 = 1'b0;
      d_imm = 32'd0;
      d_rw  = 1'b0;
      d_mr  = 1'b0;
      d_mw  = 1'b0;
      d_br  = 1'b0;
      d_jp  = 1'b0;
    end
    // x0 is hardwired, so a write to it is dropped here
    if (i_Instr[11:7] == 5'd0) d_rw = 1'b0;
    // Bubbles carry no control effect at all
    if (!i_Valid) begin
      d_rw  = 1'b0;
      d_mr  = 1'b0;
      d_mw  = 1'b0;
      d_br  = 1'b0;
      d_jp  = 1'b0;
      d_ill = 1'b0;
    end
  end

  // Pipeline register: reset > flush > stall > load
  always_ff @(posedge i_clk) begin
    if (i_rst || i_Flush) begin
      o_AluCtrl  <= ALU_ADD;
      o_Op1Sel   <= 1'b0;
      o_Op2Sel   <= 1'b0;
      o_Imm      <= 32'd0;
      o_Rs1      <= 5'd0;
      o_Rs2      <= 5'd0;
      o_Rd       <= 5'd0;
      o_Funct3   <= 3'd0;
      o_RegWrite <= 1'b0;
      o_MemRead  <= 1'b0;
      o_MemWrite <= 1'b0;
      o_Branch   <= 1'b0;
      o_Jump     <= 1'b0;
      o_Illegal  <= 1'b0;
      o_Valid    <= 1'b0;
    end else if (!i_Stall) begin
      o_AluCtrl  <= d_alu;
      o_Op1Sel   <= d_op1;
      o_Op2Sel   <= d_op2;
      o_Imm      <= d_imm;
      o_Rs1      <= i_Instr[19:15];
      o_Rs2      <= i_Instr[24:20];
      o_Rd       <= i_Instr[11:7];
      o_Funct3   <= funct3;
      o_RegWrite <= d_rw;
      o_MemRead  <= d_mr;
      o_MemWrite <= d_mw;
      o_Branch   <= d_br;
      o_Jump     <= d_jp;
      o_Illegal  <= d_ill;
      o_Valid    <= i_Valid;
    end
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb/tb_alu_decode_stage.sv - scoreboard bench for alu_decode_stage
module tb_alu_decode_stage;

  localparam logic [3:0] A_ADD  = 4'd0;
  localparam logic [3:0] A_SUB  = 4'd1;
  localparam logic [3:0] A_AND  = 4'd2;
  localparam logic [3:0] A_OR   = 4'd3;
  localparam logic [3:0] A_XOR  = 4'd4;
  localparam logic [3:0] A_SLL  = 4'd5;
  localparam logic [3:0] A_SRL  = 4'd6;
  localparam logic [3:0] A_SRA  = 4'd7;
  localparam logic [3:0] A_BUF  = 4'd8;
  localparam logic [3:0] A_SLT  = 4'd9;
  localparam logic [3:0] A_SLTU = 4'd10;

  typedef struct packed {
    logic [3:0]  alu;
    logic        op1;
    logic        op2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        jp;
    logic        ill;
    logic        v;
  } out_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_Instr = 32'd0;
  logic        i_Valid = 1'b0;
  logic        i_Stall = 1'b0;
  logic        i_Flush = 1'b0;
  logic [3:0]  o_AluCtrl;
  logic        o_Op1Sel;
  logic        o_Op2Sel;
  logic [31:0] o_Imm;
  logic [4:0]  o_Rs1;
  logic [4:0]  o_Rs2;
  logic [4:0]  o_Rd;
  logic [2:0]  o_Funct3;
  logic        o_RegWrite;
  logic        o_MemRead;
  logic        o_MemWrite;
  logic        o_Branch;
  logic        o_Jump;
  logic        o_Illegal;
  logic        o_Valid;

  int total = 0;
  int bad = 0;
  out_t exp_q[$];
  out_t model;

  alu_decode_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_Instr(i_Instr), .i_Valid(i_Valid),
    .i_Stall(i_Stall), .i_Flush(i_Flush), .o_AluCtrl(o_AluCtrl),
    .o_Op1Sel(o_Op1Sel), .o_Op2Sel(o_Op2Sel), .o_Imm(o_Imm), .o_Rs1(o_Rs1),
    .o_Rs2(o_Rs2), .o_Rd(o_Rd), .o_Funct3(o_Funct3), .o_RegWrite(o_RegWrite),
    .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite), .o_Branch(o_Branch),
    .o_Jump(o_Jump), .o_Illegal(o_Illegal), .o_Valid(o_Valid)
  );

  always #5 i_clk = ~i_clk;

  function automatic out_t bubble();
    out_t r;
    r = '0;
    r.alu = A_ADD;
    return r;
  endfunction

  // Reference decode written from the ISA rules with plain arithmetic
  function automatic out_t decode_ref(logic [31:0] ins, logic v);
    out_t r;
    logic [3:0] tab [8];
    int f3;
    int f7;
    int sv;
    logic legal;
    tab = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    legal = 1'b1;
    r = bubble();
    r.rs1 = ins[19:15];
    r.rs2 = ins[24:20];
    r.rd  = ins[11:7];
    r.f3  = ins[14:12];
    case (ins[6:0])
      7'h33: begin
        r.rw = 1'b1;
        if (f7 == 0) r.alu = tab[f3];
        else if (f7 == 32 && f3 == 0) r.alu = A_SUB;
        else if (f7 == 32 && f3 == 5) r.alu = A_SRA;
        else legal = 1'b0;
      end
      7'h13: begin
        r.rw = 1'b1;
        r.op2 = 1'b1;
        r.imm = 32'($signed(ins) >>> 20);
        if (f3 == 1 && f7 != 0) legal = 1'b0;
        else if (f3 == 5 && f7 == 32) r.alu = A_SRA;
        else if (f3 == 5 && f7 != 0) legal = 1'b0;
        else r.alu = tab[f3];
      end
      7'h37: begin
        r.alu = A_BUF; r.op2 = 1'b1; r.rw = 1'b1;
        r.imm = ins & 32'hFFFF_F000;
      end
      7'h17: begin
        r.op1 = 1'b1; r.op2 = 1'b1; r.rw = 1'b1;
        r.imm = ins & 32'hFFFF_F000;
      end
      7'h03: begin
        r.op2 = 1'b1; r.mr = 1'b1; r.rw = 1'b1;
        r.imm = 32'($signed(ins) >>> 20);
      end
      7'h23: begin
        r.op2 = 1'b1; r.mw = 1'b1;
        sv = $signed(ins) >>> 25;
        r.imm = 32'(sv * 32 + int'(ins[11:7]));
      end
      7'h63: begin
        r.alu = A_SUB; r.br = 1'b1;
        sv = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        r.imm = 32'(sv);
      end
      7'h6F: begin
        r.op1 = 1'b1; r.op2 = 1'b1; r.jp = 1'b1; r.rw = 1'b1;
        sv = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        r.imm = 32'(sv);
      end
      7'h67: begin
        r.op2 = 1'b1; r.jp = 1'b1; r.rw = 1'b1;
        r.imm = 32'($signed(ins) >>> 20);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      r.alu = A_ADD; r.op1 = 1'b0; r.op2 = 1'b0; r.imm = 32'd0;
      r.rw = 1'b0; r.mr = 1'b0; r.mw = 1'b0; r.br = 1'b0; r.jp = 1'b0;
      r.ill = 1'b1;
    end
    if (r.rd == 5'd0) r.rw = 1'b0;
    if (!v) begin
      r.rw = 1'b0; r.mr = 1'b0; r.mw = 1'b0; r.br = 1'b0; r.jp = 1'b0; r.ill = 1'b0;
    end
    r.v = v;
    return r;
  endfunction

  function automatic out_t dut_out();
    out_t a;
    a = {o_AluCtrl, o_Op1Sel, o_Op2Sel, o_Imm, o_Rs1, o_Rs2, o_Rd, o_Funct3,
         o_RegWrite, o_MemRead, o_MemWrite, o_Branch, o_Jump, o_Illegal, o_Valid};
    return a;
  endfunction

  // Drive one cycle of stimulus and push the expected registered state
  task automatic step(input logic [31:0] ins, input logic v, input logic st,
                      input logic fl, input logic rs);
    @(negedge i_clk);
    i_Instr = ins; i_Valid = v; i_Stall = st; i_Flush = fl; i_rst = rs;
    if (rs || fl) model = bubble();
    else if (!st) model = decode_ref(ins, v);
    exp_q.push_back(model);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic after_edge();
    @(posedge i_clk);
    #2;
  endtask

  // Monitor: compare every registered entry against the scoreboard
  always @(posedge i_clk) begin
    out_t e;
    out_t a;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = dut_out();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL scoreboard t=%0t: got %h expected %h", $time, a, e);
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0] opcs [10];
    int k;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h00};
    ins = $urandom;
    k = int'($urandom_range(0, 9));
    if (k < 9) ins[6:0] = opcs[k];
    else ins[6:0] = 7'($urandom);
    if ((k <= 1) && ($urandom_range(0, 3) != 0))
      ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return ins;
  endfunction

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    model = bubble();
    step(32'h0050_0093, 1'b1, 1'b1, 1'b1, 1'b1);
    after_edge();
    chk("reset_valid", 32'(o_Valid), 32'd0);
    chk("reset_alu", 32'(o_AluCtrl), 32'(A_ADD));

    step(32'h0050_0093, 1'b1, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("addi_alu", 32'(o_AluCtrl), 32'(A_ADD));
    chk("addi_imm", o_Imm, 32'd5);
    chk("addi_rd", 32'(o_Rd), 32'd1);
    chk("addi_rw_op2_v", {29'd0, o_RegWrite, o_Op2Sel, o_Valid}, 32'd7);

    for (int i = 0; i < 3; i++) begin
      step(32'h4020_81B3, 1'b1, 1'b1, 1'b0, 1'b0);
      after_edge();
      chk("stall_imm", o_Imm, 32'd5);
      chk("stall_rd", 32'(o_Rd), 32'd1);
    end
    step(32'h4020_81B3, 1'b1, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("sub_alu", 32'(o_AluCtrl), 32'(A_SUB));
    chk("sub_regs", {17'd0, o_Rs1, o_Rs2, o_Rd}, {17'd0, 5'd1, 5'd2, 5'd3});
    chk("sub_op2", 32'(o_Op2Sel), 32'd0);

    step(32'h4033_5293, 1'b1, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("srai_alu", 32'(o_AluCtrl), 32'(A_SRA));
    chk("srai_shamt", 32'(o_Imm[4:0]), 32'd3);

    step(32'h1234_53B7, 1'b1, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("lui_alu", 32'(o_AluCtrl), 32'(A_BUF));
    chk("lui_imm", o_Imm, 32'h1234_5000);
    chk("lui_rd", 32'(o_Rd), 32'd7);

    step(32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("zero_illegal", 32'(o_Illegal), 32'd1);
    chk("zero_rw", 32'(o_RegWrite), 32'd0);

    step(32'h0050_0093, 1'b1, 1'b1, 1'b1, 1'b0);
    after_edge();
    chk("flush_stall_valid", 32'(o_Valid), 32'd0);
    chk("flush_stall_rw", 32'(o_RegWrite), 32'd0);

    step(32'h0050_0093, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h4020_81B3, 1'b1, 1'b1, 1'b0, 1'b1);
    after_edge();
    chk("rst_mid_imm", o_Imm, 32'd0);
    chk("rst_mid_valid", 32'(o_Valid), 32'd0);
    step(32'h1234_53B7, 1'b1, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("post_rst_rd", 32'(o_Rd), 32'd7);

    for (int i = 0; i < 3000; i++) begin
      step(rand_instr(), $urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
    end
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge i_clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 The block SHALL have no parameters; width is fixed at RV32I, and ALU control codes are the `ADD..`SLTU macros from parameters.vh.
REQ-002 i_clk  input  1  sole clock, all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_Instr  input  32  instruction word from fetch.
REQ-005 i_Valid  input  1  i_Instr is a real instruction.
REQ-006 i_Stall  input  1  hold all outputs unchanged.
REQ-007 i_Flush  input  1  replace next registered entry with bubble.
REQ-008 o_AluCtrl  output  4  ALU operation code.
REQ-009 o_Op1Sel  output  1  0 = rs1, 1 = PC.
REQ-010 o_Op2Sel  output  1  0 = rs2, 1 = immediate.
REQ-011 o_Imm  output  32  sign-extended immediate.
REQ-012 o_Rs1, o_Rs2, o_Rd  output  5 each  register indices.
REQ-013 o_Funct3  output  3  funct3 passthrough (branch/memory width).
REQ-014 o_RegWrite, o_MemRead, o_MemWrite, o_Branch, o_Jump  output  1 each  control flags.
REQ-015 o_Illegal  output  1  unsupported opcode/funct decoded.
REQ-016 o_Valid  output  1  registered entry is a real instruction.

Function
REQ-017 All outputs SHALL be registered; latency i_Instr -> outputs exactly 1 cycle.
REQ-018 Per-edge priority SHALL be: i_rst > i_Flush > i_Stall > load.
REQ-019 Load: decode i_Instr; o_Valid <= i_Valid; when i_Valid=0, all control flags and o_Illegal SHALL load 0.
REQ-020 Stall: every output holds its value, including o_Valid.
REQ-021 Flush (including when stalled simultaneously): o_Valid, all flags, o_Illegal <= 0; o_AluCtrl <= `ADD; data fields <= 0.
REQ-022 OP (0110011): Op2Sel=0, RegWrite=1; funct3/funct7 map to ADD, SUB (f7=0100000), SLL, SLT, SLTU, XOR, SRL, SRA (f7=0100000), OR, AND.
REQ-023 OP-IMM (0010011): Op2Sel=1, I-immediate, same mapping without SUB; shifts use imm[4:0], SRAI requires f7=0100000.
REQ-024 LUI: AluCtrl=`BUF, Op2Sel=1, Imm={instr[31:12],12'b0}, RegWrite=1.
REQ-025 AUIPC: `ADD, Op1Sel=1, Op2Sel=1, U-immediate, RegWrite=1.
REQ-026 LOAD: `ADD, Op2Sel=1, I-immediate, MemRead=1, RegWrite=1; STORE: `ADD, Op2Sel=1, S-immediate, MemWrite=1.
REQ-027 BRANCH: `SUB, Op2Sel=0, B-immediate, Branch=1; JAL: `ADD, Op1Sel=1, Op2Sel=1, J-immediate, Jump=1, RegWrite=1; JALR: `ADD, Op2Sel=1, I-immediate, Jump=1, RegWrite=1.
REQ-028 Any other opcode, or invalid funct7 on OP/shift-immediate, SHALL set o_Illegal=1 with all other flags 0 and o_AluCtrl=`ADD.
REQ-029 RegWrite SHALL be forced 0 when rd=0.
REQ-030 Immediates SHALL sign-extend from instr[31]; B/J bit 0 is 0.

Reset
REQ-031 On i_rst at a clock edge, all outputs SHALL be 0, except o_AluCtrl=`ADD, regardless of i_Stall/i_Flush/i_Valid.
REQ-032 Reset asserted while an instruction is held under stall SHALL discard it; first load after reset SHALL come from i_Instr present at that edge.

Verification
REQ-033 0x00500093 (addi x1,x0,5), valid -> next cycle AluCtrl=`ADD, Op2Sel=1, Imm=5, Rd=1, RegWrite=1, o_Valid=1.
REQ-034 0x402081B3 (sub x3,x1,x2) -> `SUB, Op2Sel=0, Rs1=1, Rs2=2, Rd=3; 0x40335293 (srai x5,x6,3) -> `SRA, Imm[4:0]=3.
REQ-035 0x123453B7 (lui x7) -> `BUF, Imm=0x12345000, Rd=7; 0x00000000 -> o_Illegal=1, RegWrite=0.
REQ-036 Load addi, then hold i_Stall 3 cycles with new i_Instr applied -> outputs unchanged; release -> new instruction one cycle later.
REQ-037 i_Flush and i_Stall together with valid instruction -> o_Valid=0, flags 0; i_rst mid-stream -> all-zero outputs next edge.
